// File: rtl/core_regfile_sb_if.sv
// core_regfile_sb_if: read/forward/writeback/scoreboard bus of the core register file.
// With REGFILE_DBG_EN defined it also carries the debug read port.
interface core_regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 2
) ();
  localparam int AW = $clog2(NREG);
  logic                 i_hold;
  logic [NRD-1:0]       i_re;
  logic [NRD*AW-1:0]    i_raddr;
  logic [NRD*XLEN-1:0]  o_rdata;
  logic [NRD-1:0]       o_rbusy;
  logic [NFWD-1:0]      i_fwe;
  logic [NFWD*AW-1:0]   i_fwaddr;
  logic [NFWD*XLEN-1:0] i_fwdata;
  logic                 i_we;
  logic [AW-1:0]        i_waddr;
  logic [XLEN-1:0]      i_wdata;
  logic                 i_issue;
  logic [AW-1:0]        i_issue_addr;
  logic                 i_flush;
`ifdef REGFILE_DBG_EN
  logic [AW-1:0]        i_dbg_addr;
  logic [XLEN-1:0]      o_dbg_rdata;
  modport slave (
    input  i_hold, i_re, i_raddr, i_fwe, i_fwaddr, i_fwdata,
    input  i_we, i_waddr, i_wdata, i_issue, i_issue_addr, i_flush, i_dbg_addr,
    output o_rdata, o_rbusy, o_dbg_rdata
  );
  modport master (
    output i_hold, i_re, i_raddr, i_fwe, i_fwaddr, i_fwdata,
    output i_we, i_waddr, i_wdata, i_issue, i_issue_addr, i_flush, i_dbg_addr,
    input  o_rdata, o_rbusy, o_dbg_rdata
  );
`else
  modport slave (
    input  i_hold, i_re, i_raddr, i_fwe, i_fwaddr, i_fwdata,
    input  i_we, i_waddr, i_wdata, i_issue, i_issue_addr, i_flush,
    output o_rdata, o_rbusy
  );
  modport master (
    output i_hold, i_re, i_raddr, i_fwe, i_fwaddr, i_fwdata,
    output i_we, i_waddr, i_wdata, i_issue, i_issue_addr, i_flush,
    input  o_rdata, o_rbusy
  );
`endif
endinterface

// File: rtl/core_regfile_sb.sv
// core_regfile_sb: multi-port register file with registered reads, priority forwarding and a pending scoreboard.
// Defining REGFILE_DBG_EN adds a combinational debug read port (i_dbg_addr/o_dbg_rdata).
module core_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 2
) (
  input logic              clk,
  input logic              rst_n,
  core_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0]     cell_q [NREG];
  logic [XLEN-1:0]     cell_d [NREG];
  logic [NREG-1:0]     pend_q, pend_d;
  logic [NRD*XLEN-1:0] rdata_q, rdata_d;
  logic [NRD-1:0]      rbusy_q, rbusy_d;
  // Array and scoreboard; issue is applied after writeback so a newer producer wins, flush wins over both.
  always_comb begin
    cell_d = cell_q;
    pend_d = pend_q;
    if (bus.i_we && bus.i_waddr != '0) begin
      cell_d[bus.i_waddr] = bus.i_wdata;
      pend_d[bus.i_waddr] = 1'b0;
    end
    if (bus.i_issue) pend_d[bus.i_issue_addr] = 1'b1;
    if (bus.i_flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end
  // Forwarding loop runs high-to-low so the lowest-index match is the one that sticks.
  always_comb begin
    logic [AW-1:0]   ra;
    logic            hit;
    logic [XLEN-1:0] d;
    ra = '0;
    hit = 1'b0;
    d = '0;
    rdata_d = rdata_q;
    rbusy_d = rbusy_q;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.i_raddr[k*AW +: AW];
      hit = bus.i_we && bus.i_waddr == ra;
      d = hit ? bus.i_wdata : cell_q[ra];
      for (int j = NFWD - 1; j >= 0; j--)
        if (bus.i_fwe[j] && bus.i_fwaddr[j*AW +: AW] == ra) begin
          hit = 1'b1;
          d = bus.i_fwdata[j*XLEN +: XLEN];
        end
      if (!bus.i_hold) begin
        rdata_d[k*XLEN +: XLEN] = (bus.i_re[k] && ra != '0) ? d : '0;
        rbusy_d[k] = bus.i_re[k] && ra != '0 && pend_q[ra] && !hit;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cell_q  <= '{default: '0};
      pend_q  <= '0;
      rdata_q <= '0;
      rbusy_q <= '0;
    end else begin
      cell_q  <= cell_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  assign bus.o_rdata = rdata_q;
  assign bus.o_rbusy = rbusy_q;
`ifdef REGFILE_DBG_EN
  assign bus.o_dbg_rdata = (bus.i_dbg_addr == '0) ? '0 : cell_q[bus.i_dbg_addr];
`endif
endmodule

// File: tb/tb_core_regfile_sb.sv
// tb_core_regfile_sb: directed plan plus randomized traffic checked against an array/bit-vector model.
module tb_core_regfile_sb;
  localparam int XLEN = 32, NREG = 32, NRD = 2, NFWD = 2, AW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  core_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD)) bus ();
  core_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_pend [NREG];
  logic [XLEN-1:0] m_rd [NRD];
  bit              m_busy [NRD];
  int total = 0, bad = 0;
  logic [XLEN-1:0] saved0, saved1;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r] = '0;
      m_pend[r] = 1'b0;
    end
    for (int k = 0; k < NRD; k++) begin
      m_rd[k] = '0;
      m_busy[k] = 1'b0;
    end
  endtask
  task automatic idle();
    bus.i_hold = 0; bus.i_re = '0; bus.i_raddr = '0;
    bus.i_fwe = '0; bus.i_fwaddr = '0; bus.i_fwdata = '0;
    bus.i_we = 0; bus.i_waddr = '0; bus.i_wdata = '0;
    bus.i_issue = 0; bus.i_issue_addr = '0; bus.i_flush = 0;
`ifdef REGFILE_DBG_EN
    bus.i_dbg_addr = '0;
`endif
  endtask
  task automatic rd(int k, int a);
    bus.i_re[k] = 1'b1;
    bus.i_raddr[k*AW +: AW] = AW'(a);
  endtask
  task automatic check_outs(string tag);
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("%s_rdata%0d", tag, k), 64'(bus.o_rdata[k*XLEN +: XLEN]), 64'(m_rd[k]));
      chk($sformatf("%s_rbusy%0d", tag, k), 64'(bus.o_rbusy[k]), 64'(m_busy[k]));
    end
  endtask
  // Model: evaluate reads on pre-edge state, then apply write/scoreboard rules, then clock and compare.
  task automatic step(string tag);
    int a, src;
    bit wb;
    for (int k = 0; k < NRD; k++) begin
      a = int'(bus.i_raddr[k*AW +: AW]);
      if (!bus.i_hold) begin
        if (!bus.i_re[k] || a == 0) begin
          m_rd[k] = '0;
          m_busy[k] = 1'b0;
        end else begin
          src = -1;
          for (int j = 0; j < NFWD; j++)
            if (src < 0 && bus.i_fwe[j] && int'(bus.i_fwaddr[j*AW +: AW]) == a) src = j;
          wb = bus.i_we && int'(bus.i_waddr) == a;
          m_rd[k] = src >= 0 ? bus.i_fwdata[src*XLEN +: XLEN] : wb ? bus.i_wdata : m_reg[a];
          m_busy[k] = m_pend[a] && src < 0 && !wb;
        end
      end
    end
    if (bus.i_flush)
      for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    else begin
      if (bus.i_we && bus.i_waddr != 0) m_pend[bus.i_waddr] = 1'b0;
      if (bus.i_issue && bus.i_issue_addr != 0) m_pend[bus.i_issue_addr] = 1'b1;
    end
    if (bus.i_we && bus.i_waddr != 0) m_reg[bus.i_waddr] = bus.i_wdata;
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask
  initial begin
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_outs("in_reset");
    rst_n = 1'b1;
    check_outs("post_reset");
    rd(0, 5);
    step("rd5");
    chk("rd5_zero", 64'(bus.o_rdata[XLEN-1:0]), 64'd0);
    idle(); bus.i_we = 1; bus.i_waddr = 5'd3; bus.i_wdata = 32'hDEADBEEF;
    step("wr3");
    idle(); rd(1, 3);
    step("rd3");
    chk("rd3_val", 64'(bus.o_rdata[XLEN +: XLEN]), 64'hDEADBEEF);
    idle(); bus.i_we = 1; bus.i_waddr = 5'd0; bus.i_wdata = 32'h1234;
    step("wr0");
    idle(); rd(0, 0);
    step("rd0");
    chk("rd0_val", 64'(bus.o_rdata[XLEN-1:0]), 64'd0);
    idle(); rd(0, 7);
    bus.i_fwe = 2'b11; bus.i_fwaddr = {5'd7, 5'd7}; bus.i_fwdata = {32'hB, 32'hA};
    bus.i_we = 1; bus.i_waddr = 5'd7; bus.i_wdata = 32'hC;
    step("fwd0");
    chk("fwd0_val", 64'(bus.o_rdata[XLEN-1:0]), 64'hA);
    bus.i_fwe = 2'b10;
    step("fwd1");
    chk("fwd1_val", 64'(bus.o_rdata[XLEN-1:0]), 64'hB);
    bus.i_fwe = 2'b00;
    step("fwdwb");
    chk("fwdwb_val", 64'(bus.o_rdata[XLEN-1:0]), 64'hC);
    idle(); bus.i_issue = 1; bus.i_issue_addr = 5'd9;
    step("iss9");
    idle(); rd(0, 9);
    step("busy9");
    chk("busy9_set", 64'(bus.o_rbusy[0]), 64'd1);
    bus.i_we = 1; bus.i_waddr = 5'd9; bus.i_wdata = 32'h55;
    step("wb9");
    chk("wb9_val", 64'(bus.o_rdata[XLEN-1:0]), 64'h55);
    chk("wb9_busy", 64'(bus.o_rbusy[0]), 64'd0);
    idle(); rd(0, 9);
    step("clr9");
    chk("clr9_busy", 64'(bus.o_rbusy[0]), 64'd0);
    idle(); bus.i_issue = 1; bus.i_issue_addr = 5'd4; bus.i_we = 1; bus.i_waddr = 5'd4; bus.i_wdata = 32'h44;
    step("iswb4");
    idle(); rd(0, 4);
    step("pend4");
    chk("pend4_busy", 64'(bus.o_rbusy[0]), 64'd1);
    bus.i_flush = 1; bus.i_issue = 1; bus.i_issue_addr = 5'd4;
    step("flush4");
    idle(); rd(0, 4);
    step("flushed4");
    chk("flushed4_busy", 64'(bus.o_rbusy[0]), 64'd0);
    idle(); rd(0, 3); rd(1, 7);
    step("prehold");
    saved0 = bus.o_rdata[XLEN-1:0];
    saved1 = bus.o_rdata[XLEN +: XLEN];
    for (int i = 0; i < 3; i++) begin
      bus.i_hold = 1; rd(0, 9 + i); rd(1, 4 + i);
      bus.i_we = 1; bus.i_waddr = 5'd3; bus.i_wdata = 32'(i);
      step("hold");
      chk("hold_p0", 64'(bus.o_rdata[XLEN-1:0]), 64'(saved0));
      chk("hold_p1", 64'(bus.o_rdata[XLEN +: XLEN]), 64'(saved1));
    end
    idle(); rd(0, 3); rd(1, 7);
    step("unhold");
    chk("unhold_p0", 64'(bus.o_rdata[XLEN-1:0]), 64'd2);
`ifdef REGFILE_DBG_EN
    idle(); bus.i_we = 1; bus.i_waddr = 5'd10; bus.i_wdata = 32'h77;
    step("wr10");
    idle(); bus.i_dbg_addr = 5'd10;
    #1;
    chk("dbg10", 64'(bus.o_dbg_rdata), 64'h77);
    bus.i_dbg_addr = 5'd0;
    #1;
    chk("dbg0", 64'(bus.o_dbg_rdata), 64'd0);
    @(posedge clk);
    #1;
`endif
    for (int n = 0; n < 500; n++) begin
      bus.i_hold = $urandom_range(0, 9) == 0;
      bus.i_re = NRD'($urandom);
      for (int k = 0; k < NRD; k++) bus.i_raddr[k*AW +: AW] = AW'($urandom_range(0, 15));
      bus.i_fwe = $urandom_range(0, 2) == 0 ? NFWD'($urandom) : '0;
      for (int j = 0; j < NFWD; j++) begin
        bus.i_fwaddr[j*AW +: AW] = AW'($urandom_range(0, 15));
        bus.i_fwdata[j*XLEN +: XLEN] = $urandom;
      end
      bus.i_we = $urandom_range(0, 1) == 1;
      bus.i_waddr = AW'($urandom_range(0, 15));
      bus.i_wdata = $urandom;
      bus.i_issue = $urandom_range(0, 2) == 0;
      bus.i_issue_addr = AW'($urandom_range(0, 15));
      bus.i_flush = $urandom_range(0, 30) == 0;
      step("rand");
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("mid_reset");
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(0, 3); rd(1, 9);
    step("after_reset");
    chk("after_reset_x3", 64'(bus.o_rdata[XLEN-1:0]), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
